des_key_sched: RTL and testbench
================================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 SHALL have the clock port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have the reset port: rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have: start  input  1  request to begin a schedule; sampled only in IDLE.
REQ-004 SHALL have: key  input  64  DES key; key[n-1] = FIPS 46-3 bit n; parity bits are ignored.
REQ-005 SHALL have: decrypt  input  1  0 = emit K1..K16, 1 = emit K16..K1; sampled with start.
REQ-006 SHALL have: busy  output  1  high from the accepted start until the last handshake.
REQ-007 SHALL have: subkey  output  48  PC-2 of current C/D; subkey[n-1] = FIPS K bit n.
REQ-008 SHALL have: subkey_idx  output  4  FIPS subkey number minus 1 (0 = K1, 15 = K16).
REQ-009 SHALL have: subkey_valid  output  1  subkey and subkey_idx are valid.
REQ-010 SHALL have: subkey_ready  input  1  datapath accepts the subkey; a beat is valid & ready.
REQ-011 SHALL have: done  output  1  one-cycle pulse after the 16th beat.

Function
REQ-012 SHALL use two states: IDLE and RUN.
- IDLE -> RUN: start=1 in the cycle the key is accepted.
- RUN -> IDLE: the 16th beat.
REQ-013 SHALL load C/D registers on start acceptance (cycle t) and assert subkey_valid from cycle t+1.
- Encrypt load: C/D = PC-1(key) rotated left by 1 (that is, C1/D1).
- Decrypt load: C/D = PC-1(key) unrotated (C16/D16 = C0/D0).
REQ-014 SHALL apply the FIPS PC-1 table in full, with C and D each 28 bits; index 0 = FIPS C/D bit 1.
REQ-015 SHALL use the shift schedule for rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-016 SHALL, after an encrypt beat emitting Kn (n<16), rotate C and D left (toward index 0) by shift[n+1].
REQ-017 SHALL, after a decrypt beat emitting Kn (n>1), rotate C and D right by shift[n].
REQ-018 SHALL hold subkey, subkey_idx and C/D stable while subkey_valid=1 and subkey_ready=0.
REQ-019 SHALL support back-to-back beats: 16 subkeys in 16 consecutive cycles when subkey_ready is held at 1.
REQ-020 SHALL, on the 16th beat: clear subkey_valid and busy next cycle, and pulse done for exactly that one cycle.
REQ-021 SHALL ignore start while busy=1; key and decrypt changes mid-schedule SHALL have no effect.
REQ-022 SHALL permit start in the same cycle done is high (state is IDLE then); the new schedule's first valid follows one cycle later.
REQ-023 SHALL drive subkey combinationally from the C/D registers through PC-2, with no extra pipeline stage.

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, enter IDLE and set busy=0, subkey_valid=0, done=0, subkey_idx=0, and C/D=0 (so subkey=0).
REQ-025 SHALL let reset abort a schedule mid-operation with no further beats and no done pulse.
REQ-026 SHALL accept start in the first cycle after rst_n returns high.

Configuration
REQ-027 SHALL honour macro DES_KEY_SCHED_DECRYPT_EN.
- Defined: decrypt behaves as in REQ-005, REQ-013 and REQ-017.
- Undefined: the decrypt port exists but is ignored; the schedule is always encrypt order; right-rotate logic is not built.

Verification
REQ-028 Encrypt: key = bitrev64(0x133457799BBCDFF1), decrypt=0, ready=1, start at t.
- Cycle t+1: subkey = bitrev48(0x1B02EFFC7072), idx=0.
- Cycle t+16: subkey = bitrev48(0xCB3D8B0E17F5), idx=15.
- Cycle t+17: done=1.
REQ-029 Decrypt (macro defined): same key, decrypt=1.
- Cycle t+1: bitrev48(0xCB3D8B0E17F5), idx=15.
- Cycle t+16: bitrev48(0x1B02EFFC7072), idx=0.
REQ-030 Backpressure: ready toggles 1,0,0,1 repeatedly.
- Outputs hold during ready=0.
- Subkey sequence matches REQ-028.
- done occurs only after the 16th beat.
REQ-031 start pulsed with a different key at beat 5: ignored; the sequence completes for the original key.
REQ-032 rst_n=0 at beat 8: next cycle valid=0, busy=0, subkey=0; no done; a fresh start then yields K1 correctly.
REQ-033 Macro undefined: decrypt=1 with the REQ-028 stimulus yields the REQ-028 encrypt sequence.

Source files
------------

// File: rtl/des_key_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | des_key_sched : DES subkey generator, one subkey per valid/ready beat.      |
// | Optional decrypt order (K16..K1) enabled by macro DES_KEY_SCHED_DECRYPT_EN. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module des_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        busy,
    output logic [47:0] subkey,
    output logic [3:0]  subkey_idx,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic        done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Table entries are FIPS 1-based bit numbers.
    localparam logic [5:0] c_PC1 [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] c_PC2 [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Bit r-1 set means round r shifts by 2, otherwise by 1.
    localparam logic [15:0] c_SHIFT2 = 16'b0111_1110_1111_1100;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_idx;
    logic        r_done;
    logic        w_dec;
    logic        w_accept;
    logic        w_beat;
    logic        w_last;
    logic [3:0]  w_idx_inc;
    logic [27:0] w_c0;
    logic [27:0] w_d0;
    logic [55:0] w_cd;
    logic [7:0]  w_unused_parity;

    function automatic logic [27:0] f_rotl(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

`ifdef DES_KEY_SCHED_DECRYPT_EN
    logic r_dec;

    function automatic logic [27:0] f_rotr(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    assign w_dec = r_dec;
`else
    logic w_unused_decrypt;

    assign w_unused_decrypt = decrypt;
    assign w_dec            = 1'b0;
`endif

    assign w_unused_parity = {key[63], key[55], key[47], key[39],
                              key[31], key[23], key[15], key[7]};

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_beat    = (r_state == S_RUN) && subkey_ready;
    assign w_last    = w_beat && (w_dec ? (r_idx == 4'd0) : (r_idx == 4'd15));
    assign w_idx_inc = r_idx + 4'd1;

    always_comb begin
        w_c0 = '0;
        w_d0 = '0;
        for (int i = 0; i < 28; i++) begin
            w_c0[i] = key[c_PC1[i] - 6'd1];
            w_d0[i] = key[c_PC1[i + 28] - 6'd1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_c    <= '0;
            r_d    <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
`ifdef DES_KEY_SCHED_DECRYPT_EN
            r_dec  <= 1'b0;
`endif
        end else begin
            r_done <= w_last;
            if (w_accept) begin
`ifdef DES_KEY_SCHED_DECRYPT_EN
                r_dec <= decrypt;
                if (decrypt) begin
                    // C16/D16 equals C0/D0: total rotation over 16 rounds is 28.
                    r_c   <= w_c0;
                    r_d   <= w_d0;
                    r_idx <= 4'd15;
                end else begin
                    r_c   <= f_rotl(w_c0, 1'b0);
                    r_d   <= f_rotl(w_d0, 1'b0);
                    r_idx <= 4'd0;
                end
`else
                r_c   <= f_rotl(w_c0, 1'b0);
                r_d   <= f_rotl(w_d0, 1'b0);
                r_idx <= 4'd0;
`endif
            end else if (w_beat && !w_last) begin
`ifdef DES_KEY_SCHED_DECRYPT_EN
                if (w_dec) begin
                    r_c   <= f_rotr(r_c, c_SHIFT2[r_idx]);
                    r_d   <= f_rotr(r_d, c_SHIFT2[r_idx]);
                    r_idx <= r_idx - 4'd1;
                end else begin
                    r_c   <= f_rotl(r_c, c_SHIFT2[w_idx_inc]);
                    r_d   <= f_rotl(r_d, c_SHIFT2[w_idx_inc]);
                    r_idx <= w_idx_inc;
                end
`else
                r_c   <= f_rotl(r_c, c_SHIFT2[w_idx_inc]);
                r_d   <= f_rotl(r_d, c_SHIFT2[w_idx_inc]);
                r_idx <= w_idx_inc;
`endif
            end
        end
    end

    assign w_cd = {r_d, r_c};

    always_comb begin
        subkey = '0;
        for (int i = 0; i < 48; i++) begin
            subkey[i] = w_cd[c_PC2[i] - 6'd1];
        end
    end

    assign busy         = (r_state == S_RUN);
    assign subkey_valid = (r_state == S_RUN);
    assign subkey_idx   = r_idx;
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched.sv
`default_nettype none
// Scoreboard bench for des_key_sched using the classic 133457799BBCDFF1 key.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic        busy;
    logic [47:0] subkey;
    logic [3:0]  subkey_idx;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        done;

    always #5 clk = ~clk;

    des_key_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key          (key),
        .decrypt      (decrypt),
        .busy         (busy),
        .subkey       (subkey),
        .subkey_idx   (subkey_idx),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .done         (done)
    );

    typedef struct packed {
        logic [3:0]  idx;
        logic [47:0] sk;
        logic        last;
    } exp_t;

    // FIPS-order (bit 1 = MSB) subkeys K1..K16 of key 133457799BBCDFF1.
    localparam logic [47:0] c_K [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    localparam logic [63:0] c_KEY_FIPS = 64'h133457799BBCDFF1;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   beats   = 0;
    exp_t exp_q[$];
    logic [63:0] r_key;

    bit          hold_pend = 1'b0;
    bit          last_pend = 1'b0;
    logic [47:0] h_sk;
    logic [3:0]  h_idx;
    exp_t        e_pop;

    function automatic logic [47:0] rev48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = v[47 - i];
        return r;
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63 - i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_sched(input bit dec);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            e.idx  = dec ? 4'(15 - k) : 4'(k);
            e.sk   = rev48(c_K[e.idx]);
            e.last = (k == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [63:0] k, input bit dec);
        bit dec_eff;
`ifdef DES_KEY_SCHED_DECRYPT_EN
        dec_eff = dec;
`else
        dec_eff = 1'b0;
`endif
        push_sched(dec_eff);
        key     = k;
        decrypt = dec;
        start   = 1'b1;
        beats   = 0;
        @(posedge clk); #1;
        start   = 1'b0;
        key     = ~k;
        decrypt = ~dec;
        check("first_valid", subkey_valid, 1);
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_to_done(input bit bp, input bit inject, output int cycles);
        int cyc      = 0;
        bit injected = 1'b0;
        bit seen     = 1'b0;
        while (cyc < 400) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (inject && !injected && beats == 5) begin
                start    = 1'b1;
                key      = 64'h0123456789ABCDEF;
                decrypt  = 1'b1;
                injected = 1'b1;
            end else begin
                start = 1'b0;
            end
            subkey_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        start        = 1'b0;
        subkey_ready = 1'b1;
        cycles       = cyc;
        check("done_seen", seen, 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold/done/busy.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
                last_pend = 1'b0;
            end else begin
                check("done", done, last_pend);
                check("busy_vs_valid", busy, subkey_valid);
                if (hold_pend) begin
                    check("hold_valid", subkey_valid, 1);
                    check("hold_subkey", subkey, h_sk);
                    check("hold_idx", subkey_idx, h_idx);
                end
                hold_pend = subkey_valid && !subkey_ready;
                h_sk      = subkey;
                h_idx     = subkey_idx;
                last_pend = 1'b0;
                if (subkey_valid && subkey_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL beat: unexpected beat idx %0d, expected none", subkey_idx);
                    end else begin
                        e_pop = exp_q.pop_front();
                        check("subkey_idx", subkey_idx, e_pop.idx);
                        check("subkey", subkey, e_pop.sk);
                        last_pend = e_pop.last;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        r_key        = rev64(c_KEY_FIPS);
        rst_n        = 1'b0;
        start        = 1'b0;
        key          = '0;
        decrypt      = 1'b0;
        subkey_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", subkey_valid, 0);
        check("rst_done", done, 0);
        check("rst_idx", subkey_idx, 0);
        check("rst_subkey", subkey, 0);
        rst_n = 1'b1;

        // Encrypt, ready held high: K16 at t+16, done at t+17.
        do_start(r_key, 1'b0);
        run_to_done(1'b0, 1'b0, cyc);
        check("enc_done_latency", cyc, 16);

        // Start issued in the done cycle; decrypt order only when enabled.
        do_start(r_key, 1'b1);
        run_to_done(1'b0, 1'b0, cyc);
        check("dec_done_latency", cyc, 16);

        // Backpressure with ready pattern 1,0,0,1.
        do_start(r_key, 1'b0);
        run_to_done(1'b1, 1'b0, cyc);

        // Start with another key at beat 5 must be ignored.
        do_start(r_key, 1'b0);
        run_to_done(1'b0, 1'b1, cyc);
        check("inject_done_latency", cyc, 16);

        // Reset abort at beat 8, then immediate restart.
        do_start(r_key, 1'b0);
        cyc = 0;
        while (beats < 8 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("reach_beat8", beats, 8);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("abort_valid", subkey_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_subkey", subkey, 0);
        check("abort_idx", subkey_idx, 0);
        rst_n = 1'b1;
        do_start(r_key, 1'b0);
        run_to_done(1'b0, 1'b0, cyc);
        check("restart_done_latency", cyc, 16);

        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
